// File: rtl/mac_engine_vec.sv
// Multi-lane streaming multiply / multiply-accumulate engine: joined a/b input
// streams feed a product register, then a shift + saturate output register.
module mac_engine_vec #(
  parameter int N_LANES    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16,
  localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic [N_LANES*DATA_WIDTH-1:0] a_data_i,
  input  logic                          a_valid_i,
  output logic                          a_ready_o,
  input  logic [N_LANES*DATA_WIDTH-1:0] b_data_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  output logic [N_LANES*DATA_WIDTH-1:0] d_data_o,
  output logic                          d_valid_o,
  input  logic                          d_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [LEN_WIDTH-1:0]          cnt_o
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [LEN_WIDTH-1:0]   len_cfg;
  logic [SHIFT_WIDTH-1:0] shift_cfg;
  logic                   mode_cfg;
  logic [LEN_WIDTH-1:0]   cnt;
  logic                   p_valid, p_last;
  logic                   d_valid, d_last;

  logic stall, room, accept, last_beat, out_hs;
  logic s1_load, s2_go, out_load, acc_step, acc_zero;

  // Clamp a wide signed value into the DW-bit two's complement range.
  function automatic logic [DW-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    if ((&v[ACC_WIDTH-1:DW-1]) || ~(|v[ACC_WIDTH-1:DW-1]))
      return v[DW-1:0];
    else if (v[ACC_WIDTH-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign stall     = d_valid & ~d_ready_i;
  assign room      = cnt < len_cfg;
  assign a_ready_o = (state == RUN) & b_valid_i & ~stall & room;
  assign b_ready_o = (state == RUN) & a_valid_i & ~stall & room;
  assign accept    = a_valid_i & a_ready_o;
  assign last_beat = (cnt == len_cfg - LEN_WIDTH'(1));
  assign out_hs    = d_valid & d_ready_i;

  assign s1_load  = ~clear_i & ~stall & accept;
  assign s2_go    = ~clear_i & ~stall & p_valid;
  assign out_load = s2_go & (~mode_cfg | p_last);
  assign acc_step = s2_go & mode_cfg & ~p_last;
  assign acc_zero = clear_i | (s2_go & mode_cfg & p_last);

  assign d_valid_o = d_valid;
  assign cnt_o     = cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = (len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (accept && last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (out_hs && d_last) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_cfg   <= '0;
      shift_cfg <= '0;
      mode_cfg  <= 1'b0;
      cnt       <= '0;
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      d_valid   <= 1'b0;
      d_last    <= 1'b0;
    end else if (clear_i) begin
      cnt     <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      d_valid <= 1'b0;
      d_last  <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        len_cfg   <= len_i;
        shift_cfg <= shift_i;
        mode_cfg  <= mode_i;
        cnt       <= '0;
      end else if (accept) begin
        cnt <= cnt + LEN_WIDTH'(1);
      end
      // Both stages freeze together while the output is back-pressured.
      if (!stall) begin
        p_valid <= accept;
        p_last  <= accept & last_beat;
        d_valid <= p_valid & (~mode_cfg | p_last);
        d_last  <= p_valid & p_last;
      end
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic signed [DW-1:0]        a_lane, b_lane;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, acc, acc_sum;
    logic [DW-1:0]               res;

    assign a_lane   = a_data_i[gi*DW +: DW];
    assign b_lane   = b_data_i[gi*DW +: DW];
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_sum  = acc + prod_ext;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        prod <= '0;
        acc  <= '0;
        res  <= '0;
      end else begin
        if (s1_load) prod <= PW'(a_lane) * PW'(b_lane);
        if (acc_zero)      acc <= '0;
        else if (acc_step) acc <= acc_sum;
        // The final ACC beat folds its product in here instead of via acc.
        if (out_load)
          res <= mode_cfg ? sat(acc_sum >>> shift_cfg) : sat(prod_ext >>> shift_cfg);
      end
    end

    assign d_data_o[gi*DW +: DW] = res;
  end

endmodule

// File: doc/mac_engine_vec.md
Name: mac_engine_vec

Overview:
Parametrised multi-lane successor to the single-lane MAC engine in the HWPE MAC accelerator. It joins two operand streams (a, b) of N_LANES signed lanes each and multiplies them lane-wise. In MUL mode it emits one product per input beat. In ACC mode it accumulates LEN beats per lane and emits one result beat. Results are arithmetic-shifted and saturated to DATA_WIDTH. The block sits between the streamer source ports and the streamer sink port, and the HWPE controller drives it through start, clear and config signals.

Parameters:
N_LANES, 4, number of independent signed lanes per stream beat
DATA_WIDTH, 16, per-lane operand and result width (two's complement)
ACC_WIDTH, 40, per-lane accumulator width (>= 2*DATA_WIDTH)
LEN_WIDTH, 16, width of beat-count configuration and counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous soft clear, highest priority after reset
start_i  in  1  start pulse, sampled only in IDLE
mode_i  in  1  0 = MUL (per-beat output), 1 = ACC (one output per job)
len_i  in  LEN_WIDTH  number of input beats in job, latched at start
shift_i  in  $clog2(ACC_WIDTH)  right arithmetic shift before saturation, latched at start
a_data_i  in  N_LANES*DATA_WIDTH  operand a, lane k at bits [k*DW +: DW]
a_valid_i  in  1  a valid
a_ready_o  out  1  a ready
b_data_i  in  N_LANES*DATA_WIDTH  operand b
b_valid_i  in  1  b valid
b_ready_o  out  1  b ready
d_data_o  out  N_LANES*DATA_WIDTH  result
d_valid_o  out  1  result valid
d_ready_i  in  1  result ready
busy_o  out  1  high in RUN and DRAIN
done_o  out  1  one-cycle pulse at job end
cnt_o  out  LEN_WIDTH  input beats accepted in current job

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; accumulators, product registers and latched config cleared.
- States: IDLE -> RUN on start_i (len_i>0). IDLE -> DONE on start_i with len_i=0: no beats consumed, done_o pulses the next cycle. RUN -> DRAIN when the LEN-th input beat is accepted. DRAIN -> DONE when the final output handshake occurs. DONE -> IDLE after 1 cycle, with done_o=1 during DONE.
- start_i outside IDLE is ignored.
- Stall = d_valid_o & ~d_ready_i.
- Input join: a_ready_o = RUN & b_valid_i & ~stall & (cnt_o<len). b_ready_o = RUN & a_valid_i & ~stall & (cnt_o<len). A beat is accepted when a_valid_i & b_valid_i & a_ready_o. Neither stream is consumed alone.
- Stage 1 (product register): each lane stores the signed DWxDW product (2*DW bits) and sets p_valid. The stage holds its contents while stalled.
- Stage 2:
  - MUL: the output register loads sat(prod >>> shift) for every product.
  - ACC: acc += sign-extended prod. The accumulator wraps (two's complement) on overflow. On the last product the output register loads sat((acc+prod) >>> shift) and the accumulator returns to 0.
  - Stage 2 does not write while stalled.
- Saturation: values clamp to [-2^(DW-1), 2^(DW-1)-1].
- Latency: from beat acceptance at cycle t (MUL), or last-beat acceptance at t (ACC), d_valid_o is asserted at t+2 with no stall.
- d_data_o and d_valid_o are held stable until d_ready_i. With d_ready_i tied high, throughput is 1 beat/cycle.
- cnt_o increments per accepted beat and resets to 0 on start_i.
- clear_i: next cycle state IDLE. Pipeline is flushed, accumulators 0, d_valid_o 0, cnt_o 0, no done_o. clear_i wins over a simultaneous start_i.
- Async reset mid-job aborts identically to clear_i, but immediately.

Test Plan:
- DW=16, N_LANES=4, MUL, len=3, shift=0. All lanes a=3, b=-2, valid every cycle. -> d_data lanes=-6 (0xFFFA) on 3 consecutive beats. First d_valid 2 cycles after first acceptance. done_o one pulse after 3rd handshake. cnt_o=3.
- ACC, len=4, a=b=1000 all lanes. With shift=8 -> single beat, each lane 15625. With shift=4 -> 250000 saturates to 32767. Exactly one output beat.
- MUL, len=2, lane0 a=-32768, b=32767, shift=0 -> -32768 (no wrap). Lane1 a=b=-32768, shift=0 -> saturates to 32767.
- Backpressure: MUL, len=8, d_ready_i low for 5 cycles mid-stream. -> a_ready_o/b_ready_o low while stalled, d_data_o stable, all 8 results in order, none lost or duplicated.
- Skewed valids: a_valid_i high, b_valid_i low for 3 cycles. -> a_ready_o=0, no beat consumed, cnt_o unchanged.
- clear_i after 2 of 8 ACC beats. -> next cycle busy_o=0, d_valid_o=0, no done_o. A new ACC job len=1 with a=b=2, shift=0 outputs 4 (accumulator starts clean). Separately, start_i with len=0 gives done_o 1 cycle later with no handshakes.
